// File: rtl/ps2_scan_pkg.sv
// ps2_scan_pkg: definitions shared by the PS/2 scancode input block.
//   - sequencer opcodes decoded from inst[11:8]
//   - receiver FSM state encoding
//   - bit positions of the status byte, plus a helper that assembles it
`timescale 1ns/1ps
package ps2_scan_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_RDC = 4'h1,
        OP_RDS = 4'h2,
        OP_CLR = 4'h3
    } opcode_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    localparam int unsigned STAT_OVF_BIT   = 7;
    localparam int unsigned STAT_ERR_BIT   = 6;
    localparam int unsigned STAT_EMPTY_BIT = 5;

    // Status byte: {ovf, err, empty, 0, count[3:0]}
    function automatic logic [7:0] make_status(logic ovf, logic err, logic empty,
                                               logic [3:0] count);
        logic [7:0] s;
        s                 = {4'b0000, count};
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_ERR_BIT]   = err;
        s[STAT_EMPTY_BIT] = empty;
        return s;
    endfunction

endpackage

// File: rtl/ps2_scan_input_if.sv
// ps2_scan_input_if: sequencer-side bundle for the PS/2 scancode block.
//   inst[11:0] : instruction, opcode in [11:8], immediate in [7:0]
//   inst_en    : instruction valid this cycle
//   out[7:0]   : registered result returned to the sequencer
// master = sequencer (drives inst/inst_en), slave = ps2_scan_input side.
`timescale 1ns/1ps
interface ps2_scan_input_if;
    logic [11:0] inst;
    logic        inst_en;
    logic [7:0]  out;

    modport master (output inst, output inst_en, input  out);
    modport slave  (input  inst, input  inst_en, output out);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
//   clock, reset    : system clock (rising edge), async active-low reset
//   ps2_clk/data    : asynchronous PS/2 lines, 2-flop synchronized here
//   rx_byte[7:0]    : received data byte (valid while rx_valid/rx_err)
//   rx_valid        : one-cycle pulse, frame had odd parity and stop=1
//   rx_err          : one-cycle pulse, frame failed parity or stop check
// A frame stalled in SHIFT for TimeoutCycles cycles is silently dropped.
`timescale 1ns/1ps
module ps2_frame_rx
    import ps2_scan_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic clk_s, data_s, fall;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        stop_d      = stop_q;
        tmo_d       = tmo_q;
        rx_valid    = 1'b0;
        rx_err      = 1'b0;

        case (state_q)
            RX_IDLE: begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                if (fall && !data_s) begin
                    state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    tmo_d = '0;
                    // Samples 0..8 are data LSB first then parity, shifted in
                    // from the top; sample 9 is the stop bit.
                    if (bit_cnt_q == 4'd9) begin
                        stop_d  = data_s;
                        state_d = RX_CHECK;
                    end else begin
                        shift_d   = {data_s, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RX_CHECK: begin
                if ((^shift_q) && stop_q) begin
                    rx_valid = 1'b1;
                end else begin
                    rx_err = 1'b1;
                end
                state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_byte = shift_q[7:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RX_IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            stop_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            stop_q      <= stop_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_scan_input.sv
// ps2_scan_input: PS/2 keyboard scancode input for a sequencer.
//   clock, reset    : system clock (rising edge), async active-low reset
//   inst[11:0]      : instruction, [11:8] opcode, [7:0] ignored
//   inst_en         : instruction valid this cycle
//   out[7:0]        : registered result (RDC = FIFO head, RDS = status)
//   ps2_clk/data    : asynchronous PS/2 lines from the keyboard
// Received bytes go into a FifoDepth-entry FIFO; err/ovf are sticky flags
// cleared only by CLR or reset.
`timescale 1ns/1ps
module ps2_scan_input
    import ps2_scan_pkg::*;
#(
    parameter int unsigned FifoDepth     = 4,
    parameter int unsigned TimeoutCycles = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [7:0]  out,
    input  logic        ps2_clk,
    input  logic        ps2_data
);

    localparam int unsigned PW = $clog2(FifoDepth);
    localparam logic [3:0]    DEPTH    = 4'(FifoDepth);
    localparam logic [PW-1:0] PTR_LAST = PW'(FifoDepth - 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    logic [7:0]    mem_q [FifoDepth];
    logic [7:0]    mem_d [FifoDepth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    out_q, out_d;

    logic          empty, full, is_rdc, is_rds, is_clr;
    logic          pop, push, push_acc;
    logic          unused_imm;

    ps2_frame_rx #(
        .TimeoutCycles(TimeoutCycles)
    ) u_rx (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign unused_imm = ^inst[7:0];

    function automatic logic [PW-1:0] ptr_next(logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        out_d    = out_q;

        empty  = (count_q == 4'd0);
        full   = (count_q == DEPTH);
        is_rdc = inst_en && (inst[11:8] == OP_RDC);
        is_rds = inst_en && (inst[11:8] == OP_RDS);
        is_clr = inst_en && (inst[11:8] == OP_CLR);

        // A pop frees the slot the same cycle, so a push into a full FIFO
        // alongside a pop is accepted. CLR overrides any incoming byte.
        pop      = is_rdc && !empty;
        push     = rx_valid && !is_clr;
        push_acc = push && (!full || pop);

        if (is_rdc) begin
            out_d = empty ? 8'h00 : mem_q[rd_ptr_q];
        end else if (is_rds) begin
            out_d = make_status(ovf_q, err_q, empty, count_q);
        end

        if (is_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (rx_err) begin
                err_d = 1'b1;
            end
            if (push && !push_acc) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push_acc) begin
                mem_d[wr_ptr_q] = rx_byte;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (push_acc && !pop) begin
                count_d = count_q + 4'd1;
            end else if (pop && !push_acc) begin
                count_d = count_q - 4'd1;
            end
        end
    end

    assign out = out_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            out_q    <= 8'h00;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_ps2_scan_input.sv
`timescale 1ns/1ps
module tb_ps2_scan_input;
    import ps2_scan_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TMO      = 200;
    localparam int unsigned PS2_HALF = 30000;   // 60 us PS/2 clock period

    logic clock    = 1'b0;
    logic reset    = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_scan_input_if bus ();

    always #500 clock = ~clock;   // 1 MHz system clock

    ps2_scan_input #(
        .FifoDepth    (DEPTH),
        .TimeoutCycles(TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (bus.inst),
        .inst_en (bus.inst_en),
        .out     (bus.out),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model (queue based) ----------------
    logic [7:0] m_q[$];
    bit         m_err = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_out = 8'h00;

    function automatic logic [7:0] m_status();
        return {m_ovf, m_err, (m_q.size() == 0), 1'b0, 4'(m_q.size())};
    endfunction

    function automatic void m_frame(logic [7:0] d, bit ok);
        if (!ok) m_err = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
    endfunction

    function automatic void m_clear();
        m_q.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
    endfunction

    function automatic void m_inst(logic [3:0] op);
        case (op)
            4'h1: m_out = (m_q.size() == 0) ? 8'h00 : m_q.pop_front();
            4'h2: m_out = m_status();
            4'h3: m_clear();
            default: ;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [7:0] got, logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(logic [7:0] d, bit bad_par, bit bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Bits go out LSB first; data changes while ps2_clk is high.
    task automatic send_bits(logic [10:0] bits, int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            #(PS2_HALF);
            ps2_clk = 1'b0;
            #(PS2_HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] d, bit bad_par, bit bad_stop);
        send_bits(frame_bits(d, bad_par, bad_stop), 11);
        repeat (8) @(negedge clock);
    endtask

    task automatic issue(logic [3:0] op, output logic [7:0] r);
        @(negedge clock);
        bus.inst    = {op, 8'($urandom)};
        bus.inst_en = 1'b1;
        @(negedge clock);
        bus.inst_en = 1'b0;
        bus.inst    = 12'($urandom);
        r = bus.out;
    endtask

    // Send a frame and present `op` during the cycle the byte is pushed.
    task automatic op_in_check(logic [7:0] d, logic [3:0] op, output logic [7:0] r);
        r = 8'hxx;
        fork
            send_bits(frame_bits(d, 1'b0, 1'b0), 11);
            begin
                int k;
                k = 0;
                while (dut.u_rx.rx_valid !== 1'b1 && k < 2000) begin
                    @(negedge clock);
                    k++;
                end
                if (k >= 2000) begin
                    check("wait_push", 8'h00, 8'h01);
                end else begin
                    bus.inst    = {op, 8'h00};
                    bus.inst_en = 1'b1;
                    @(negedge clock);
                    bus.inst_en = 1'b0;
                    r = bus.out;
                end
            end
        join
        repeat (4) @(negedge clock);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         is_frame;
        logic [7:0] dat;
        bit         bad_par;
        bit         bad_stop;
        logic [3:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void addf(logic [7:0] d, bit bp, bit bs);
        vec_t v;
        v = '{1'b1, d, bp, bs, 4'h0, 8'h00};
        tbl.push_back(v);
    endfunction

    function automatic void addi(logic [3:0] op, logic [7:0] exp);
        vec_t v;
        v = '{1'b0, 8'h00, 1'b0, 1'b0, op, exp};
        tbl.push_back(v);
    endfunction

    initial begin
        #(90_000_000);
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [7:0] r;

        bus.inst    = 12'h000;
        bus.inst_en = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_out", bus.out, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        addi(4'h2, 8'h20);                      // status after reset
        addi(4'h1, 8'h00);                      // RDC on empty
        addf(8'hF0, 1'b1, 1'b0);                // bad parity
        addi(4'h2, 8'h60);
        addi(4'h0, 8'h60);                      // NOP holds out
        addi(4'hA, 8'h60);                      // undefined op holds out
        addi(4'h1, 8'h00);
        addi(4'h3, 8'h00);                      // CLR leaves out
        addi(4'h2, 8'h20);
        for (int i = 1; i <= 5; i++) addf(8'(i), 1'b0, 1'b0);
        addi(4'h2, 8'h84);
        addi(4'h1, 8'h01);
        addi(4'h1, 8'h02);
        addi(4'h1, 8'h03);
        addi(4'h1, 8'h04);
        addi(4'h2, 8'hA0);
        addi(4'h1, 8'h00);
        addf(8'h12, 1'b0, 1'b1);                // bad stop bit
        addi(4'h2, 8'hE0);
        addi(4'h3, 8'hE0);
        addi(4'h2, 8'h20);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_frame) begin
                send_frame(tbl[i].dat, tbl[i].bad_par, tbl[i].bad_stop);
                m_frame(tbl[i].dat, !(tbl[i].bad_par || tbl[i].bad_stop));
            end else begin
                issue(tbl[i].op, r);
                m_inst(tbl[i].op);
                check($sformatf("tbl%0d", i), r, tbl[i].exp);
            end
        end

        // Byte 0x1C visible in count 4 cycles after the stop-bit falling edge.
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 10);
        ps2_data = 1'b1;
        #(PS2_HALF);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clock);
        issue(4'h2, r);
        check("latency_rds", r, 8'h01);
        #(PS2_HALF - 5000);
        ps2_clk = 1'b1;
        repeat (8) @(negedge clock);
        issue(4'h1, r);
        check("rdc_1c", r, 8'h1C);
        issue(4'h2, r);
        check("rds_after_1c", r, 8'h20);

        // Abandoned partial frame: start + 4 data bits, then long idle.
        send_bits(frame_bits(8'hA5, 1'b0, 1'b0), 5);
        repeat (TMO + 100) @(negedge clock);
        send_frame(8'h5A, 1'b0, 1'b0);
        issue(4'h1, r);
        check("timeout_rdc", r, 8'h5A);
        issue(4'h2, r);
        check("timeout_rds", r, 8'h20);

        // Full FIFO: push and pop in the same cycle are both accepted.
        for (int i = 1; i <= 4; i++) send_frame(8'(8'h11 * i), 1'b0, 1'b0);
        op_in_check(8'h55, 4'h1, r);
        check("full_pushpop", r, 8'h11);
        issue(4'h2, r);
        check("full_pp_rds", r, 8'h04);
        for (int i = 2; i <= 5; i++) begin
            issue(4'h1, r);
            check("full_pp_rdc", r, 8'(8'h11 * i));
        end

        // CLR coincident with a push drops the incoming byte.
        send_frame(8'h66, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b1);
        op_in_check(8'h88, 4'h3, r);
        issue(4'h2, r);
        check("clr_in_check", r, 8'h20);
        issue(4'h1, r);
        check("clr_in_chk_rdc", r, 8'h00);

        // Reset after the 6th data bit; first frame after release is kept.
        send_frame(8'h0F, 1'b1, 1'b0);
        issue(4'h2, r);
        check("pre_reset_rds", r, 8'h60);
        send_bits(frame_bits(8'hC3, 1'b0, 1'b0), 7);
        reset = 1'b0;
        #3000;
        check("reset_out_mid", bus.out, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        m_clear();
        m_out = 8'h00;
        repeat (2) @(negedge clock);
        send_frame(8'h33, 1'b0, 1'b0);
        issue(4'h1, r);
        check("rst_rdc", r, 8'h33);
        issue(4'h2, r);
        check("rst_rds", r, 8'h20);
        m_out = 8'h20;

        // Randomized traffic against the queue model.
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                logic [7:0] d;
                int kind;
                d    = 8'($urandom);
                kind = int'($urandom_range(0, 9));
                send_frame(d, kind == 8, kind == 9);
                m_frame(d, kind < 8);
            end else if (sel == 4) begin
                @(negedge clock);
                bus.inst    = {4'h1, 8'($urandom)};
                bus.inst_en = 1'b0;
                @(negedge clock);
                @(negedge clock);
                check("rand_noen", bus.out, m_out);
            end else begin
                logic [3:0] op;
                op = (sel == 9) ? 4'($urandom) : 4'($urandom_range(0, 3));
                issue(op, r);
                m_inst(op);
                check($sformatf("rand_op%0h", op), r, m_out);
            end
        end
        issue(4'h2, r);
        m_inst(4'h2);
        check("rand_final", r, m_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_scan_input.md
PS2_SCAN_INPUT -- requirements
Module: ps2_scan_input

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, scancode FIFO entries (2..15).
REQ-002 SHALL have parameter TimeoutCycles, default 50000, idle clock cycles before a partial frame is abandoned.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port inst  input  12  sequencer instruction: [11:8] opcode, [7:0] immediate (ignored).
REQ-006 SHALL have port inst_en  input  1  instruction valid this cycle.
REQ-007 SHALL have port out  output  8  registered result to sequencer ireg slot 3.
REQ-008 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock from keyboard.
REQ-009 SHALL have port ps2_data  input  1  asynchronous PS/2 data from keyboard.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; falling edge = synced clk 1 then 0 on consecutive cycles.
REQ-011 SHALL use receiver FSM IDLE -> SHIFT -> CHECK -> IDLE; IDLE moves to SHIFT on a falling edge with ps2_data=0 (start bit), otherwise stays.
REQ-012 SHALL in SHIFT sample ps2_data on each falling edge: 8 data bits LSB first, then odd parity, then stop; after the stop sample go to CHECK.
REQ-013 SHALL in CHECK (one cycle) push the byte if parity odd and stop=1; else discard and set sticky err; return to IDLE.
REQ-014 SHALL count cycles since last falling edge in SHIFT; at TimeoutCycles return to IDLE, discard partial byte, not set err.
REQ-015 SHALL make a valid byte visible in the FIFO count no later than 4 clock cycles after the stop-bit falling edge of ps2_clk.
REQ-016 SHALL hold FIFO order first-in-first-out with wrapping read/write pointers and count 0..FifoDepth.
REQ-017 SHALL on push with count=FifoDepth and no simultaneous pop drop the byte and set sticky ovf.
REQ-018 SHALL on push and pop in the same cycle with FIFO full accept both (count unchanged, no ovf).
REQ-019 SHALL decode opcodes when inst_en=1: NOP=4'h0 no effect; RDC=4'h1 out<=FIFO head and pop; RDS=4'h2 out<=status; CLR=4'h3 flush FIFO, clear err and ovf, out unchanged; others behave as NOP.
REQ-020 SHALL format status as {ovf, err, empty, 1'b0, count[3:0]}.
REQ-021 SHALL on RDC with FIFO empty set out<=8'h00 and leave pointers unchanged.
REQ-022 SHALL update out on the clock edge that samples the instruction (1-cycle latency) and hold it otherwise.
REQ-023 SHALL on CLR coincident with a CHECK push discard the incoming byte (CLR wins, count=0 afterwards).
REQ-024 SHALL ignore inst when inst_en=0.

Reset
REQ-025 SHALL on reset low asynchronously force out=8'h00, FSM=IDLE, FIFO count/pointers=0, err=0, ovf=0, timeout counter=0, synchronizers=1.
REQ-026 SHALL on reset mid-frame discard the partial byte; after release, the first frame accepted is one whose start bit falls after release.

Structure
REQ-027 SHALL place opcodes (NOP, RDC, RDS, CLR), FSM state encoding and status bit positions in shared package ps2_scan_pkg.
REQ-028 SHALL implement the synchronizer, FSM and timeout in sub-module ps2_frame_rx (outputs byte, byte_valid, frame_err); FIFO and decode stay in ps2_scan_input.

Verification
REQ-029 SHALL cover: frame 0x1C, parity 0, stop 1, ps2_clk 60 us period -> RDS gives 8'h01, RDC gives 8'h1C, RDS gives 8'h20.
REQ-030 SHALL cover: frame 0xF0 with parity bit 0 (bad) -> RDS gives 8'h60, RDC gives 8'h00.
REQ-031 SHALL cover: 5 valid frames 0x01..0x05, FifoDepth=4, no reads -> RDS gives 8'h84; RDC x4 returns 0x01,0x02,0x03,0x04.
REQ-032 SHALL cover: 4 data bits then ps2_clk idle > TimeoutCycles, then full frame 0x5A -> RDC gives 8'h5A, err=0.
REQ-033 SHALL cover: FIFO full with ovf and err set, CLR -> RDS gives 8'h20; CLR in the CHECK cycle of a frame -> count 0.
REQ-034 SHALL cover: reset asserted after 6th data bit, released, full frame 0x33 -> RDC gives 8'h33, RDS gives 8'h20.
